// File: rtl/debug_scan_pkg.sv
// rtl/debug_scan_pkg.sv - shared scan state encoding and default widths for the debug scan master
package debug_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    RTI,
    DONE
  } scan_state_t;

  localparam int DEFAULT_DR_W = 38;
  localparam int DEFAULT_IR_W = 2;

endpackage

// File: rtl/debug_scan_tck_gen.sv
// rtl/debug_scan_tck_gen.sv - tck divider with single-clk fall/rise ticks, forced low when disabled
module debug_scan_tck_gen #(
  parameter int TCK_HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int CW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          run_q, run_d;
  logic          half_end;

  // The first enabled cycle is itself a period start, so the scan begins one clk after enable.
  always_comb begin
    half_end  = (cnt_q == CW'(TCK_HALF - 1));
    fall_tick = en && (!run_q || (tck_q && half_end));
    rise_tick = en && run_q && !tck_q && half_end;
    cnt_d     = cnt_q + 1'b1;
    tck_d     = tck_q;
    run_d     = run_q;
    if (!en) begin
      cnt_d = '0;
      tck_d = 1'b0;
      run_d = 1'b0;
    end else if (fall_tick) begin
      cnt_d = '0;
      tck_d = 1'b0;
      run_d = 1'b1;
    end else if (rise_tick) begin
      cnt_d = '0;
      tck_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
      run_q <= run_d;
    end
  end

  assign tck = tck_q;

endmodule

// File: rtl/debug_slave_scan_master.sv
// rtl/debug_slave_scan_master.sv - system-clock virtual-JTAG scan initiator for the CPU debug slave
// Define DEBUG_SCAN_IR_CACHE_EN to skip UIR when the requested IR is already loaded.
module debug_slave_scan_master
  import debug_scan_pkg::*;
#(
  parameter int DR_W       = DEFAULT_DR_W,
  parameter int IR_W       = DEFAULT_IR_W,
  parameter int TCK_HALF   = 2,
  parameter int RTI_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [IR_W-1:0] req_ir,
  input  logic [DR_W-1:0] req_dr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DR_W-1:0] rsp_dr,
  output logic [IR_W-1:0] rsp_ir_out,
  output logic            vji_tck,
  output logic            vji_tdi,
  input  logic            vji_tdo,
  output logic [IR_W-1:0] vji_ir_in,
  input  logic [IR_W-1:0] vji_ir_out,
  output logic            vji_uir,
  output logic            vji_cdr,
  output logic            vji_sdr,
  output logic            vji_udr,
  output logic            vji_rti
);

  localparam int CNT_W = $clog2(DR_W + RTI_CYCLES + 1);

  scan_state_t     state_q, state_d;
  logic            first_q, first_d;
  logic [IR_W-1:0] req_ir_q, req_ir_d;
  logic [IR_W-1:0] ir_in_q, ir_in_d;
  logic [IR_W-1:0] ir_out_q, ir_out_d;
  logic [DR_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            tdi_q, tdi_d;
  logic            busy, live, skip_uir;
  logic            fall_tick, rise_tick;

  assign busy = (state_q != IDLE) && (state_q != DONE);

  debug_scan_tck_gen #(.TCK_HALF(TCK_HALF)) u_tck_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (busy),
    .tck       (vji_tck),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

`ifdef DEBUG_SCAN_IR_CACHE_EN
  logic ir_valid_q, ir_valid_d;

  assign skip_uir = ir_valid_q && (req_ir == ir_in_q);

  always_comb begin
    ir_valid_d = ir_valid_q;
    if (fall_tick && first_q && (state_q == UIR)) ir_valid_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ir_valid_q <= 1'b0;
    else       ir_valid_q <= ir_valid_d;
  end
`else
  assign skip_uir = 1'b0;
`endif

  // state_q already names the first period on acceptance; first_q holds the strobes off until it begins.
  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    req_ir_d = req_ir_q;
    ir_in_d  = ir_in_q;
    ir_out_d = ir_out_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    tdi_d    = tdi_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = skip_uir ? CDR : UIR;
          first_d  = 1'b1;
          req_ir_d = req_ir;
          shift_d  = req_dr;
          cnt_d    = '0;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: begin
        if (fall_tick) begin
          if (first_q) begin
            first_d = 1'b0;
          end else begin
            case (state_q)
              UIR: state_d = CDR;
              CDR: begin
                state_d = SDR;
                cnt_d   = '0;
              end
              SDR: begin
                if (cnt_q == CNT_W'(DR_W - 1)) state_d = UDR;
                else cnt_d = cnt_q + 1'b1;
              end
              UDR: begin
                state_d = RTI;
                cnt_d   = '0;
              end
              RTI: begin
                if (cnt_q == CNT_W'(RTI_CYCLES - 1)) state_d = DONE;
                else cnt_d = cnt_q + 1'b1;
              end
              default: state_d = IDLE;
            endcase
          end
          if (state_d == UIR) ir_in_d = req_ir_q;
          tdi_d = (state_d == SDR) ? shift_q[0] : 1'b0;
        end
        if (rise_tick) begin
          if (state_q == CDR) ir_out_d = vji_ir_out;
          if (state_q == SDR) shift_d = {vji_tdo, shift_q[DR_W-1:1]};
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      first_q  <= 1'b0;
      req_ir_q <= '0;
      ir_in_q  <= '0;
      ir_out_q <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      tdi_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      req_ir_q <= req_ir_d;
      ir_in_q  <= ir_in_d;
      ir_out_q <= ir_out_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      tdi_q    <= tdi_d;
    end
  end

  assign live       = busy && !first_q;
  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == DONE);
  assign rsp_dr     = shift_q;
  assign rsp_ir_out = ir_out_q;
  assign vji_tdi    = tdi_q;
  assign vji_ir_in  = ir_in_q;
  assign vji_uir    = live && (state_q == UIR);
  assign vji_cdr    = live && (state_q == CDR);
  assign vji_sdr    = live && (state_q == SDR);
  assign vji_udr    = live && (state_q == UDR);
  assign vji_rti    = live && (state_q == RTI);

endmodule
